// File: rtl/mult_leak_pkg.sv
// rtl/mult_leak_pkg.sv - shared states, default parameters and helpers for the multiplier leak monitor
package mult_leak_pkg;

  typedef enum logic [1:0] {IDLE, RUN, REPORT} leakState_t;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_LAT_W  = 8;
  localparam int DEF_STAT_W = 16;

  // A copy is declared hung once its latency counter reaches this value.
  function automatic int defTimeout(input int width);
    return 2 * width + 8;
  endfunction

  function automatic logic [31:0] satInc(input logic [31:0] value, input int width);
    logic [31:0] maxVal;
    maxVal = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= maxVal) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/mult_leak_if.sv
// rtl/mult_leak_if.sv - start, done and operand bundle shared by both multiplier copies and the monitor
interface mult_leak_if import mult_leak_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic             done_one;
  logic             done_two;
  logic [WIDTH-1:0] op_mult_one;
  logic [WIDTH-1:0] op_mcand_one;
  logic [WIDTH-1:0] op_mult_two;
  logic [WIDTH-1:0] op_mcand_two;

  modport master (
    output start, done_one, done_two,
    output op_mult_one, op_mcand_one, op_mult_two, op_mcand_two
  );

  modport slave (
    input start, done_one, done_two,
    input op_mult_one, op_mcand_one, op_mult_two, op_mcand_two
  );
endinterface

// File: rtl/mult_leak_lat_cnt.sv
// rtl/mult_leak_lat_cnt.sv - per-copy start-to-done latency counter with timeout detection
module mult_leak_lat_cnt import mult_leak_pkg::*; #(
  parameter int LAT_W   = DEF_LAT_W,
  parameter int TIMEOUT = defTimeout(DEF_WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic             done,
  output logic [LAT_W-1:0] lat,
  output logic             doneFlag,
  output logic             timeoutFlag
);
  localparam logic [LAT_W-1:0] TIMEOUT_V = LAT_W'(TIMEOUT);

  logic [LAT_W-1:0] count;
  logic [LAT_W-1:0] latReg;
  logic             seen;
  logic             hitNow;

  // Outputs already reflect this cycle's done so the verdict can be taken on the same edge.
  always_comb begin
    timeoutFlag = enable && !seen && (count == TIMEOUT_V);
    hitNow      = enable && !seen && !timeoutFlag && done;
    doneFlag    = seen || hitNow;
    if (seen) begin
      lat = latReg;
    end else if (timeoutFlag) begin
      lat = TIMEOUT_V;
    end else begin
      lat = count + LAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count  <= '0;
      latReg <= '0;
      seen   <= 1'b0;
    end else if (enable) begin
      if (hitNow) begin
        seen   <= 1'b1;
        latReg <= count + LAT_W'(1);
      end else if (!seen && !timeoutFlag) begin
        count <= count + LAT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mult_leak_monitor.sv
// rtl/mult_leak_monitor.sv - per-trial latency compare of two multiplier copies with leak statistics
// Optional operand/latency capture of the first leaking trial: LEAK_CAPTURE_EN.
module mult_leak_monitor import mult_leak_pkg::*; #(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LAT_W   = DEF_LAT_W,
  parameter int TIMEOUT = defTimeout(WIDTH),
  parameter int STAT_W  = DEF_STAT_W
) (
  input  logic              clk,
  input  logic              rst,
  mult_leak_if.slave        mul,
  output logic              busy,
  output logic              result_valid,
  output logic              leak,
  output logic              hang,
  output logic [LAT_W-1:0]  lat_one,
  output logic [LAT_W-1:0]  lat_two,
  output logic [STAT_W-1:0] trial_count,
  output logic [STAT_W-1:0] leak_count,
  output logic              sticky_leak
`ifdef LEAK_CAPTURE_EN
  ,
  output logic              cap_valid,
  output logic [WIDTH-1:0]  cap_mult_one,
  output logic [WIDTH-1:0]  cap_mcand_one,
  output logic [WIDTH-1:0]  cap_mult_two,
  output logic [WIDTH-1:0]  cap_mcand_two,
  output logic [LAT_W-1:0]  cap_lat_one,
  output logic [LAT_W-1:0]  cap_lat_two
`endif
);

  leakState_t       state, stateNext;
  logic             acceptStart, goReport, runEn;
  logic [LAT_W-1:0] latOne, latTwo;
  logic             doneOne, doneTwo, toOne, toTwo;
  logic             hangNow, leakNow;

  assign runEn        = (state == RUN);
  assign busy         = (state != IDLE);
  assign result_valid = (state == REPORT);
  assign hangNow      = toOne || toTwo;
  assign leakNow      = (latOne != latTwo) || hangNow;

  mult_leak_lat_cnt #(.LAT_W(LAT_W), .TIMEOUT(TIMEOUT)) u_cnt_one (
    .clk(clk), .rst(rst), .clear(acceptStart), .enable(runEn), .done(mul.done_one),
    .lat(latOne), .doneFlag(doneOne), .timeoutFlag(toOne)
  );

  mult_leak_lat_cnt #(.LAT_W(LAT_W), .TIMEOUT(TIMEOUT)) u_cnt_two (
    .clk(clk), .rst(rst), .clear(acceptStart), .enable(runEn), .done(mul.done_two),
    .lat(latTwo), .doneFlag(doneTwo), .timeoutFlag(toTwo)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext   = state;
    acceptStart = 1'b0;
    goReport    = 1'b0;
    case (state)
      IDLE: begin
        if (mul.start) begin
          acceptStart = 1'b1;
          stateNext   = RUN;
        end
      end
      RUN: begin
        if ((doneOne && doneTwo) || hangNow) begin
          goReport  = 1'b1;
          stateNext = REPORT;
        end
      end
      REPORT:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Verdict and statistics land on the RUN->REPORT edge so they are valid with result_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      leak        <= 1'b0;
      hang        <= 1'b0;
      lat_one     <= '0;
      lat_two     <= '0;
      trial_count <= '0;
      leak_count  <= '0;
      sticky_leak <= 1'b0;
    end else if (goReport) begin
      leak        <= leakNow;
      hang        <= hangNow;
      lat_one     <= latOne;
      lat_two     <= latTwo;
      trial_count <= STAT_W'(satInc(32'(trial_count), STAT_W));
      if (leakNow) begin
        leak_count <= STAT_W'(satInc(32'(leak_count), STAT_W));
      end
      sticky_leak <= sticky_leak || leakNow;
    end
  end

`ifdef LEAK_CAPTURE_EN
  logic [WIDTH-1:0] sMultOne, sMcandOne, sMultTwo, sMcandTwo;

  always_ff @(posedge clk) begin
    if (rst) begin
      sMultOne      <= '0;
      sMcandOne     <= '0;
      sMultTwo      <= '0;
      sMcandTwo     <= '0;
      cap_valid     <= 1'b0;
      cap_mult_one  <= '0;
      cap_mcand_one <= '0;
      cap_mult_two  <= '0;
      cap_mcand_two <= '0;
      cap_lat_one   <= '0;
      cap_lat_two   <= '0;
    end else begin
      if (acceptStart) begin
        sMultOne  <= mul.op_mult_one;
        sMcandOne <= mul.op_mcand_one;
        sMultTwo  <= mul.op_mult_two;
        sMcandTwo <= mul.op_mcand_two;
      end
      if (goReport && leakNow && !cap_valid) begin
        cap_valid     <= 1'b1;
        cap_mult_one  <= sMultOne;
        cap_mcand_one <= sMcandOne;
        cap_mult_two  <= sMultTwo;
        cap_mcand_two <= sMcandTwo;
        cap_lat_one   <= latOne;
        cap_lat_two   <= latTwo;
      end
    end
  end
`endif

endmodule
